// File: rtl/wave_ram.sv
// wave_ram: single-clock wavetable RAM with a looping playback pointer.
//
// Random-access writes load the waveform; each `step` strobe reads the
// sample at the playback pointer into a registered output and advances the
// pointer, wrapping from loop_end (or the last word) back to loop_start.
// `out_valid` and `wrap` pulse in the cycle after the reading edge.
//
// Build option:
//   WAVE_RAM_BYPASS_EN  defined   -> write-first: a read of the address being
//                                    written in the same cycle returns wr_data.
//                       undefined -> read-first: such a read returns the old
//                                    word; no forwarding path exists.
module wave_ram #(
   parameter  int WIDTH = 20,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             step,
   input  logic             restart,
   input  logic [AW-1:0]    loop_start,
   input  logic [AW-1:0]    loop_end,
   output logic [AW-1:0]    ptr,
   output logic [WIDTH-1:0] out,
   output logic             out_valid,
   output logic             wrap
);

   // Last legal word address, and DEPTH widened by one bit so address
   // range checks work for both power-of-two and odd depths.
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
   localparam logic [AW:0]   DEPTH_X = (AW + 1)'(DEPTH);

   // One read request per cycle, resolved combinationally from the strobes.
   typedef struct packed {
      logic          rd;     // a sample is read this edge
      logic [AW-1:0] ra;     // address being read
      logic          wrap;   // the read sits at the loop end / last word
   } rd_req_t;

   logic [WIDTH-1:0] mem [DEPTH];

   rd_req_t         req;
   logic            wr_ok;
   logic [AW-1:0]   ls_ok;
   logic [AW-1:0]   nxt_ptr;
   logic [WIDTH-1:0] rd_word;

   // Loop end reached when the address matches loop_end or the top word;
   // the second term is what keeps a loop_start > loop_end setting (or a
   // loop_end beyond the array) from running off the end.
   function automatic logic at_end(input logic [AW-1:0] a,
                                   input logic [AW-1:0] le);
      return (a == le) || (a == LAST);
   endfunction

   // Write qualification: addresses past the array are silently dropped.
   assign wr_ok = load && ({1'b0, wr_addr} < DEPTH_X);

   // A loop_start outside the array would put ptr out of range; fall back
   // to word 0 so the pointer can never hold an illegal address.
   assign ls_ok = ({1'b0, loop_start} < DEPTH_X) ? loop_start : '0;

   // Read request and next pointer; restart has priority over the pointer.
   always_comb begin
      req      = '0;
      req.rd   = step;
      req.ra   = restart ? ls_ok : ptr;
      req.wrap = step && at_end(req.ra, loop_end);
      nxt_ptr  = ptr;
      if (step)
         nxt_ptr = at_end(req.ra, loop_end) ? ls_ok : req.ra + 1'b1;
      else if (restart)
         nxt_ptr = ls_ok;
   end

   // Read data source: forwarded write data or the stored (old) word.
`ifdef WAVE_RAM_BYPASS_EN
   always_comb begin
      rd_word = mem[req.ra];
      if (wr_ok && (wr_addr == req.ra))
         rd_word = wr_data;
   end
`else
   assign rd_word = mem[req.ra];
`endif

   // Storage array; deliberately not reset so the waveform survives rst.
   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_addr] <= wr_data;
   end

   // Pointer, registered sample and the valid/wrap strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
         wrap      <= 1'b0;
      end else begin
         ptr       <= nxt_ptr;
         out_valid <= req.rd;
         wrap      <= req.wrap;
         if (req.rd)
            out <= rd_word;
      end
   end

endmodule

// File: tb/tb_wave_ram.sv
// tb_wave_ram: scoreboard bench for wave_ram. Two instances (DEPTH=64 and
// DEPTH=48) share one stimulus stream; a reference model predicts each read,
// pushes it to a per-instance queue, and a monitor pops on out_valid.
module tb_wave_ram;

   localparam int W  = 20;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load = 1'b0, step = 1'b0, restart = 1'b0;
   logic [AW-1:0] wr_addr = '0, loop_start = '0, loop_end = '0;
   logic [W-1:0]  wr_data = '0;

   logic [AW-1:0] ptr0, ptr1;
   logic [W-1:0]  out0, out1;
   logic          vld0, vld1, wrap0, wrap1;

   wave_ram #(.WIDTH(W), .DEPTH(64)) u0 (
      .clk(clk), .rst(rst), .load(load), .wr_addr(wr_addr), .wr_data(wr_data),
      .step(step), .restart(restart), .loop_start(loop_start), .loop_end(loop_end),
      .ptr(ptr0), .out(out0), .out_valid(vld0), .wrap(wrap0));

   wave_ram #(.WIDTH(W), .DEPTH(48)) u1 (
      .clk(clk), .rst(rst), .load(load), .wr_addr(wr_addr), .wr_data(wr_data),
      .step(step), .restart(restart), .loop_start(loop_start), .loop_end(loop_end),
      .ptr(ptr1), .out(out1), .out_valid(vld1), .wrap(wrap1));

   always #5 clk = ~clk;

   typedef struct { logic [W-1:0] d; logic w; } exp_t;
   exp_t q0[$], q1[$];

   int tests = 0, fails = 0;

   // reference state per instance
   logic [W-1:0] mm [2][64];
   int           pm [2];
   logic [W-1:0] lout [2];
   bit           ev [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Spec-level model of one clock edge, evaluated with the inputs that edge saw.
   task automatic model();
      for (int k = 0; k < 2; k++) begin
         int d, ra, ls, le;
         bit hit;
         logic [W-1:0] v;
         exp_t e;
         d   = (k == 0) ? 64 : 48;
         ls  = int'(loop_start);
         le  = int'(loop_end);
         ra  = restart ? ls : pm[k];
         hit = (ra == le) || (ra == d - 1);
         if (step) begin
            v = mm[k][ra];
`ifdef WAVE_RAM_BYPASS_EN
            if (load && int'(wr_addr) < d && int'(wr_addr) == ra) v = wr_data;
`endif
            e.d = v; e.w = hit;
            if (k == 0) q0.push_back(e); else q1.push_back(e);
            lout[k] = v;
            pm[k]   = hit ? ls : ra + 1;
         end else if (restart) begin
            pm[k] = ls;
         end
         ev[k] = step;
         if (load && int'(wr_addr) < d) mm[k][int'(wr_addr)] = wr_data;
      end
   endtask

   // One clock: apply inputs, let the edge happen, model it, check the state.
   task automatic cyc(input bit ld, input int wa, input int wd, input bit st, input bit rs);
      load = ld; wr_addr = AW'(wa); wr_data = W'(wd); step = st; restart = rs;
      @(posedge clk);
      model();
      #1;
      chk("ptr0", 32'(ptr0), 32'(pm[0]));
      chk("ptr1", 32'(ptr1), 32'(pm[1]));
      chk("valid0", 32'(vld0), 32'(ev[0]));
      chk("valid1", 32'(vld1), 32'(ev[1]));
      if (!ev[0]) chk("hold0", 32'(out0), 32'(lout[0]));
      if (!ev[1]) chk("hold1", 32'(out1), 32'(lout[1]));
   endtask

   task automatic idle();
      cyc(0, 0, 0, 0, 0);
   endtask

   // Monitor: every presented sample must match the oldest prediction.
   always @(negedge clk) begin
      if (vld0) begin
         tests++;
         if (q0.size() == 0) begin
            fails++; $display("FAIL sample0: unexpected output %0h", out0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            if (out0 !== e.d || wrap0 !== e.w) begin
               fails++;
               $display("FAIL sample0: got %0h/%0b expected %0h/%0b at %0t", out0, wrap0, e.d, e.w, $time);
            end
         end
      end
      if (vld1) begin
         tests++;
         if (q1.size() == 0) begin
            fails++; $display("FAIL sample1: unexpected output %0h", out1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            if (out1 !== e.d || wrap1 !== e.w) begin
               fails++;
               $display("FAIL sample1: got %0h/%0b expected %0h/%0b at %0t", out1, wrap1, e.d, e.w, $time);
            end
         end
      end
   end

   initial begin
      for (int k = 0; k < 2; k++) begin pm[k] = 0; lout[k] = '0; ev[k] = 0; end

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ptr", 32'({ptr0, ptr1}), 32'd0);
      chk("rst_out", 32'(out0 | out1), 32'd0);
      chk("rst_flags", 32'({vld0, vld1, wrap0, wrap1}), 32'd0);
      rst = 1'b0;

      // load ramp i*3, full-range loop, 66 back-to-back steps
      for (int i = 0; i < 64; i++) cyc(1, i, i * 3, 0, 0);
      loop_start = 6'd0; loop_end = 6'd63;
      for (int i = 0; i < 66; i++) cyc(0, 0, 0, 1, 0);
      idle();

      // short loop 10..12 starting from pointer 0
      cyc(0, 0, 0, 0, 1);
      loop_start = 6'd10; loop_end = 6'd12;
      for (int i = 0; i < 18; i++) cyc(0, 0, 0, 1, 0);

      // restart+step from ptr=40, then restart alone
      loop_start = 6'd40; loop_end = 6'd63;
      cyc(0, 0, 0, 0, 1);
      loop_start = 6'd5;
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 0, 1);

      // read-during-write at address 7
      cyc(1, 7, 'h00111, 0, 0);
      loop_start = 6'd7;
      cyc(0, 0, 0, 0, 1);
      cyc(1, 7, 'hABCDE, 1, 0);
      cyc(0, 0, 0, 1, 1);
      idle();

      // loop_end beyond DEPTH=48, then out-of-range write
      loop_start = 6'd44; loop_end = 6'd60;
      cyc(0, 0, 0, 0, 1);
      for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 0);
      cyc(1, 50, 'h12345, 0, 0);
      loop_start = 6'd2;
      cyc(0, 0, 0, 1, 1);
      idle();

      // asynchronous reset in the cycle after a step
      loop_start = 6'd20; loop_end = 6'd30;
      cyc(0, 0, 0, 1, 1);
      cyc(0, 0, 0, 1, 0);
      load = 0; step = 0; restart = 0;
      rst = 1'b1;
      q0.delete(); q1.delete();
      #1;
      chk("arst_out", 32'(out0 | out1), 32'd0);
      chk("arst_valid", 32'({vld0, vld1}), 32'd0);
      chk("arst_ptr", 32'({ptr0, ptr1}), 32'd0);
      for (int k = 0; k < 2; k++) begin pm[k] = 0; lout[k] = '0; ev[k] = 0; end
      @(negedge clk);
      rst = 1'b0;
      idle();
      cyc(0, 0, 0, 1, 0);
      cyc(0, 0, 0, 1, 0);

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         if ($urandom_range(0, 15) == 0) begin
            loop_start = AW'($urandom_range(0, 47));
            loop_end   = AW'($urandom_range(0, 63));
         end
         cyc($urandom_range(0, 2) == 0, int'($urandom_range(0, 63)), int'($urandom & 32'hFFFFF),
             $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      end
      idle();
      idle();

      chk("drain0", 32'(q0.size()), 32'd0);
      chk("drain1", 32'(q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
